floating_point_multiplier: RTL
==============================

FLOATING_POINT_MULTIPLIER -- requirements
Module: floating_point_multiplier

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 23, fraction field width; total word W = 1+EXP_WIDTH+FRAC_WIDTH.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fp_a_i  input  W  operand A, {sign, exp, frac}.
REQ-006 SHALL have port fp_b_i  input  W  operand B, same format.
REQ-007 SHALL have port valid_i  input  1  operands valid this cycle.
REQ-008 SHALL have port fp_o  output  W  product A*B.
REQ-009 SHALL have port valid_o  output  1  fp_o valid this cycle.

Function
REQ-010 SHALL be a 4-stage pipeline: operands sampled on edge N with valid_i=1 appear on fp_o with valid_o=1 after edge N+4; latency fixed.
REQ-011 SHALL accept one operation per cycle, no backpressure, no stalls; back-to-back operations complete in issue order, one per cycle.
REQ-012 SHALL carry a valid bit per stage; stage data registers load only when that stage's incoming valid is 1, otherwise hold.
REQ-013 SHALL hold fp_o at its last value while valid_o=0.
REQ-014 Stage 1 SHALL unpack, classify each operand (zero, normal, inf, nan), sign = sA xor sB, exponent sum eA+eB-bias in EXP_WIDTH+2-bit signed arithmetic, mantissas with hidden 1.
REQ-015 Stage 2 SHALL register the full 2*(FRAC_WIDTH+1)-bit unsigned mantissa product.
REQ-016 Stage 3 SHALL normalize: product MSB set -> shift right 1, exponent+1; derive guard, round, sticky (OR of all lower bits).
REQ-017 Stage 4 SHALL round to nearest, ties to even; rounding carry-out -> mantissa 1.0, exponent+1; then range check and special override.
REQ-018 Subnormal inputs (exp=0, frac!=0) SHALL be treated as zero of same sign (flush-to-zero).
REQ-019 Final biased exponent <= 0 SHALL give signed zero (flush underflow, no subnormal output).
REQ-020 Final biased exponent >= all-ones SHALL give signed infinity.
REQ-021 Any NaN input, or inf*zero, SHALL give canonical qNaN: sign 0, exp all ones, frac MSB 1, rest 0 (0x7FC00000 at defaults).
REQ-022 inf*nonzero-finite or inf*inf SHALL give infinity with sign xor; zero*finite SHALL give zero with sign xor.
REQ-023 No exception flags; no rounding-mode input.

Reset
REQ-024 While rst_i=1 at an edge, all stage valid bits, valid_o and fp_o SHALL clear to 0.
REQ-025 Reset mid-operation SHALL discard all in-flight operations; valid_o=0 the cycle after the reset edge; no stale result after release.
REQ-026 valid_i sampled during reset SHALL be ignored; first operation after release obeys REQ-010.

Structure
REQ-027 Shared package floating_point_pkg SHALL hold the operand class enum, bias and canonical-qNaN constant functions of EXP_WIDTH/FRAC_WIDTH, reused by divider and multiplier.
REQ-028 Rounding/renormalization (REQ-016/017 datapath) SHALL be one combinational sub-module floating_point_rounder, parameterized identically, shareable with floating_point_divider.
REQ-029 Bench SHALL reuse the existing generator/driver/monitor/scoreboard flow with a multiply golden model of latency 4, single- and double-precision variants.

Verification
REQ-030 0x40400000 * 0x40000000 (3.0*2.0), valid_i one cycle -> fp_o=0x40C00000, valid_o high exactly 4 cycles later, one cycle only.
REQ-031 0x3FC00000*0x3FC00000 -> 0x40100000 (normalize shift); 0x3F800001*0x3F800001 -> 0x3F800002 (rounding).
REQ-032 0x7F800000*0x00000000 -> 0x7FC00000; 0xFF800000*0x40000000 -> 0xFF800000; 0x7FC00001*0x3F800000 -> 0x7FC00000; 0x80000000*0x40000000 -> 0x80000000.
REQ-033 0x7F7FFFFF*0x40000000 -> 0x7F800000; 0x00800000*0x00800000 -> 0x00000000; 0x00000001*0x40000000 -> 0x00000000.
REQ-034 16 back-to-back valid operations -> 16 consecutive valid outputs in order; rst_i pulsed after op 8 -> valid_o 0 next cycle, no further outputs until new valid_i.
REQ-035 10^6 random operand pairs -> zero scoreboard mismatches against golden model.

Source files
------------

// File: rtl/floating_point_pkg.sv
// Shared definitions for the floating-point multiplier and divider:
// operand classes plus bias and canonical quiet-NaN values as functions of
// the exponent and fraction widths.
package floating_point_pkg;

  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_NORMAL = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_e;

  // Exponent bias: 2^(exp_width-1) - 1.
  function automatic int fp_bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

  // Canonical qNaN: sign 0, exponent all ones, fraction MSB set, rest 0.
  // Returned in a 64-bit container; callers slice the low word.
  function automatic logic [63:0] fp_qnan(input int exp_width, input int frac_width);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_width; i++) v[frac_width + i] = 1'b1;
    v[frac_width - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/floating_point_rounder.sv
// Combinational normalize / round-to-nearest-even / range check / special
// override. The normalize half feeds one pipeline register, the rounding
// half the next, so the same block serves any pipelined FP datapath.
module floating_point_rounder
  import floating_point_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  // normalize section
  input  logic [2*FRAC_WIDTH+1:0]        prod,
  input  logic signed [EXP_WIDTH+1:0]    prod_exp,
  output logic [FRAC_WIDTH:0]            norm_mant,
  output logic                           norm_guard,
  output logic                           norm_round,
  output logic                           norm_sticky,
  output logic signed [EXP_WIDTH+1:0]    norm_exp,
  // rounding section
  input  logic [FRAC_WIDTH:0]            mant,
  input  logic                           guard,
  input  logic                           round,
  input  logic                           sticky,
  input  logic signed [EXP_WIDTH+1:0]    exp_in,
  input  logic                           sign,
  input  fp_class_e                      cls_a,
  input  fp_class_e                      cls_b,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]  result
);

  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam logic [63:0] QNAN_FULL = fp_qnan(EXP_WIDTH, FRAC_WIDTH);
  localparam logic [W-1:0] QNAN = QNAN_FULL[W-1:0];
  localparam logic signed [EXP_WIDTH+1:0] EXP_ONE  = (EXP_WIDTH+2)'(1);
  localparam logic signed [EXP_WIDTH+1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_WIDTH+1:0] EXP_MAX  = $signed({2'b00, {EXP_WIDTH{1'b1}}});

  logic [FRAC_WIDTH+1:0]         mant_sum;
  logic                          round_up;
  logic [FRAC_WIDTH-1:0]         frac_r;
  logic signed [EXP_WIDTH+1:0]   exp_r;

  // Product in [1,4): a set MSB means the value is >= 2, so shift right once.
  always_comb begin
    norm_mant   = prod[2*FRAC_WIDTH:FRAC_WIDTH];
    norm_guard  = prod[FRAC_WIDTH-1];
    norm_round  = prod[FRAC_WIDTH-2];
    norm_sticky = |prod[FRAC_WIDTH-3:0];
    norm_exp    = prod_exp;
    if (prod[2*FRAC_WIDTH+1]) begin
      norm_mant   = prod[2*FRAC_WIDTH+1:FRAC_WIDTH+1];
      norm_guard  = prod[FRAC_WIDTH];
      norm_round  = prod[FRAC_WIDTH-1];
      norm_sticky = |prod[FRAC_WIDTH-2:0];
      norm_exp    = prod_exp + EXP_ONE;
    end
  end

  // Round to nearest even, then flush underflow, saturate overflow to inf,
  // and let operand classes override the numeric result.
  always_comb begin
    round_up = guard & (round | sticky | mant[0]);
    mant_sum = {1'b0, mant} + {{(FRAC_WIDTH+1){1'b0}}, round_up};
    frac_r   = mant_sum[FRAC_WIDTH-1:0];
    exp_r    = exp_in;
    if (mant_sum[FRAC_WIDTH+1]) begin
      // all-ones mantissa rounded up to 2.0: becomes 1.0 with exponent+1
      frac_r = '0;
      exp_r  = exp_in + EXP_ONE;
    end
    result = {sign, exp_r[EXP_WIDTH-1:0], frac_r};
    if (exp_r <= EXP_ZERO) result = {sign, {(W-1){1'b0}}};
    else if (exp_r >= EXP_MAX) result = {sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_INF && cls_b == FP_ZERO) || (cls_a == FP_ZERO && cls_b == FP_INF))
      result = QNAN;
    else if (cls_a == FP_INF || cls_b == FP_INF)
      result = {sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    else if (cls_a == FP_ZERO || cls_b == FP_ZERO)
      result = {sign, {(W-1){1'b0}}};
  end

endmodule

// File: rtl/floating_point_multiplier.sv
// Pipelined IEEE-style multiplier: input capture, unpack/classify, mantissa
// product, normalize, round. Fixed latency, one operation per cycle.
//
// Handshake: valid-only. An operation is accepted on every rising edge with
// valid_i=1 and rst_i=0; there is no ready and the pipeline never stalls.
// fp_o is meaningful when valid_o=1 and holds its last value otherwise.
module floating_point_multiplier
  import floating_point_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_a_i,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_b_i,
  input  logic                          valid_i,
  output logic [EXP_WIDTH+FRAC_WIDTH:0] fp_o,
  output logic                          valid_o
);

  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam logic signed [EXP_WIDTH+1:0] BIAS_X = (EXP_WIDTH+2)'(fp_bias(EXP_WIDTH));

  function automatic fp_class_e classify(input logic [EXP_WIDTH-1:0] e,
                                         input logic [FRAC_WIDTH-1:0] f);
    if (e == '0) return FP_ZERO;   // subnormals flush to zero
    if (&e) return (f == '0) ? FP_INF : FP_NAN;
    return FP_NORMAL;
  endfunction

  logic                          s0_valid, s1_valid, s2_valid, s3_valid;
  logic [W-1:0]                  s0_a, s0_b;
  logic                          s1_sign, s2_sign, s3_sign;
  logic signed [EXP_WIDTH+1:0]   s1_exp, s2_exp, s3_exp;
  logic [FRAC_WIDTH:0]           s1_ma, s1_mb, s3_mant;
  fp_class_e                     s1_cls_a, s1_cls_b, s2_cls_a, s2_cls_b, s3_cls_a, s3_cls_b;
  logic [2*FRAC_WIDTH+1:0]       s2_prod;
  logic                          s3_guard, s3_round, s3_sticky;

  logic [FRAC_WIDTH:0]           n_mant;
  logic                          n_guard, n_round, n_sticky;
  logic signed [EXP_WIDTH+1:0]   n_exp;
  logic [W-1:0]                  rounded;

  floating_point_rounder #(
    .EXP_WIDTH  (EXP_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_rounder (
    .prod        (s2_prod),
    .prod_exp    (s2_exp),
    .norm_mant   (n_mant),
    .norm_guard  (n_guard),
    .norm_round  (n_round),
    .norm_sticky (n_sticky),
    .norm_exp    (n_exp),
    .mant        (s3_mant),
    .guard       (s3_guard),
    .round       (s3_round),
    .sticky      (s3_sticky),
    .exp_in      (s3_exp),
    .sign        (s3_sign),
    .cls_a       (s3_cls_a),
    .cls_b       (s3_cls_b),
    .result      (rounded)
  );

  // Valid chain and output word; reset flushes every in-flight operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      valid_o  <= 1'b0;
      fp_o     <= '0;
    end else begin
      s0_valid <= valid_i;
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      valid_o  <= s3_valid;
      if (s3_valid) fp_o <= rounded;
    end
  end

  // Stage data; each register loads only when its incoming valid is set.
  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      s0_a <= fp_a_i;
      s0_b <= fp_b_i;
    end
    if (s0_valid) begin
      s1_sign  <= s0_a[W-1] ^ s0_b[W-1];
      s1_exp   <= $signed({2'b00, s0_a[W-2:FRAC_WIDTH]}) +
                  $signed({2'b00, s0_b[W-2:FRAC_WIDTH]}) - BIAS_X;
      s1_ma    <= {1'b1, s0_a[FRAC_WIDTH-1:0]};
      s1_mb    <= {1'b1, s0_b[FRAC_WIDTH-1:0]};
      s1_cls_a <= classify(s0_a[W-2:FRAC_WIDTH], s0_a[FRAC_WIDTH-1:0]);
      s1_cls_b <= classify(s0_b[W-2:FRAC_WIDTH], s0_b[FRAC_WIDTH-1:0]);
    end
    if (s1_valid) begin
      s2_sign  <= s1_sign;
      s2_exp   <= s1_exp;
      s2_prod  <= {{(FRAC_WIDTH+1){1'b0}}, s1_ma} * {{(FRAC_WIDTH+1){1'b0}}, s1_mb};
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
    end
    if (s2_valid) begin
      s3_sign   <= s2_sign;
      s3_exp    <= n_exp;
      s3_mant   <= n_mant;
      s3_guard  <= n_guard;
      s3_round  <= n_round;
      s3_sticky <= n_sticky;
      s3_cls_a  <= s2_cls_a;
      s3_cls_b  <= s2_cls_b;
    end
  end

endmodule
